// File: rtl/regfile_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_scoreboard_pkg
//  Purpose  : Shared register-file defaults and zero-register convention,
//             reused by decode and hazard logic.
//  Revision : 1.0  initial release
// ============================================================================
package regfile_scoreboard_pkg;

   localparam int DEF_DATA_W   = 64;
   localparam int DEF_NUM_REGS = 32;
   localparam int DEF_NUM_RD   = 2;

   // The hard-wired zero register is the highest architectural index.
   function automatic int zero_reg_of(input int num_regs);
      return num_regs - 1;
   endfunction

endpackage : regfile_scoreboard_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_scoreboard_if
//  Purpose  : Read, writeback and reservation bundle of the register file
//             scoreboard. master = pipeline side, slave = register file.
//  Revision : 1.0  initial release
// ============================================================================
interface regfile_scoreboard_if
   import regfile_scoreboard_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int NUM_RD   = DEF_NUM_RD
);
   localparam int ADDR_W = $clog2(NUM_REGS);

   logic [NUM_RD*ADDR_W-1:0] RdAddr;
   logic [NUM_RD*DATA_W-1:0] RdData;
   logic [NUM_RD-1:0]        RdReady;
   logic                     WrEn;
   logic [ADDR_W-1:0]        WrAddr;
   logic [DATA_W-1:0]        WrData;
   logic                     RsvEn;
   logic [ADDR_W-1:0]        RsvAddr;
   logic                     RsvStall;
   logic [ADDR_W:0]          PendingCnt;

   modport master (
      output RdAddr, WrEn, WrAddr, WrData, RsvEn, RsvAddr,
      input  RdData, RdReady, RsvStall, PendingCnt
   );

   modport slave (
      input  RdAddr, WrEn, WrAddr, WrData, RsvEn, RsvAddr,
      output RdData, RdReady, RsvStall, PendingCnt
   );

endinterface : regfile_scoreboard_if
`default_nettype wire

// File: rtl/regfile_scoreboard_read_port.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_read_port
//  Purpose  : One combinational read port: zero-register decode, same-cycle
//             writeback bypass, stored-value mux and readiness flag.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_read_port #(
   parameter int DATA_W   = 64,
   parameter int NUM_REGS = 32,
   parameter int ZERO_REG = NUM_REGS - 1,
   localparam int ADDR_W  = $clog2(NUM_REGS)
) (
   input  logic              hold_zero,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] regs [NUM_REGS],
   input  logic [NUM_REGS-1:0] busy,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_ready
);
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

   // Priority: reset forces zero/ready, then zero register, then bypass,
   // then storage with readiness taken from the busy bit.
   always_comb begin
      rd_data  = '0;
      rd_ready = 1'b1;
      if (!hold_zero) begin
         if (rd_addr == ZERO_ADDR) begin
            rd_data  = '0;
            rd_ready = 1'b1;
         end else if (wr_en && (wr_addr == rd_addr)) begin
            rd_data  = wr_data;
            rd_ready = 1'b1;
         end else begin
            rd_data  = regs[rd_addr];
            rd_ready = ~busy[rd_addr];
         end
      end
   end

endmodule : regfile_read_port
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_scoreboard
//  Purpose  : Multi-port register file with per-register busy scoreboard,
//             WAW reservation stall, same-cycle bypass and pending count.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_scoreboard
   import regfile_scoreboard_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int NUM_RD   = DEF_NUM_RD,
   parameter int ZERO_REG = zero_reg_of(NUM_REGS)
) (
   input  logic Clk,
   input  logic ResetN,
   regfile_scoreboard_if.slave rf
);
   localparam int ADDR_W = $clog2(NUM_REGS);
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

   logic [DATA_W-1:0]   r_regs [NUM_REGS];
   logic [NUM_REGS-1:0] r_busy;
   logic [NUM_REGS-1:0] w_busy_next;
   logic [ADDR_W:0]     r_pending;
   logic [ADDR_W:0]     w_pending_next;
   logic                w_rsv_stall;
   logic                w_rsv_set;
   logic [NUM_RD*DATA_W-1:0] w_rd_data;
   logic [NUM_RD-1:0]        w_rd_ready;

   // WAW hazard: a pending writer blocks a new reservation unless it is
   // retiring on the very same cycle.
   always_comb begin
      w_rsv_stall = ResetN && rf.RsvEn && (rf.RsvAddr != ZERO_ADDR)
                    && r_busy[rf.RsvAddr]
                    && !(rf.WrEn && (rf.WrAddr == rf.RsvAddr));
      w_rsv_set   = rf.RsvEn && !w_rsv_stall && (rf.RsvAddr != ZERO_ADDR);
   end

   // Next busy vector: writeback clears first so a same-address reservation
   // (the new writer) wins; zero register never becomes busy.
   always_comb begin
      w_busy_next = r_busy;
      if (rf.WrEn) begin
         w_busy_next[rf.WrAddr] = 1'b0;
      end
      if (w_rsv_set) begin
         w_busy_next[rf.RsvAddr] = 1'b1;
      end
      w_busy_next[ZERO_ADDR] = 1'b0;
   end

   // Population count of the next busy vector, registered as PendingCnt.
   always_comb begin
      w_pending_next = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         w_pending_next = w_pending_next + {{ADDR_W{1'b0}}, w_busy_next[i]};
      end
   end

   // Register storage; zero-register writes are dropped.
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (rf.WrEn && (rf.WrAddr != ZERO_ADDR)) begin
         r_regs[rf.WrAddr] <= rf.WrData;
      end
   end

   // Scoreboard state and its registered population count.
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         r_busy    <= '0;
         r_pending <= '0;
      end else begin
         r_busy    <= w_busy_next;
         r_pending <= w_pending_next;
      end
   end

   generate
      for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_port
         regfile_read_port #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS),
            .ZERO_REG (ZERO_REG)
         ) u_read_port (
            .hold_zero (~ResetN),
            .rd_addr   (rf.RdAddr[g*ADDR_W +: ADDR_W]),
            .regs      (r_regs),
            .busy      (r_busy),
            .wr_en     (rf.WrEn),
            .wr_addr   (rf.WrAddr),
            .wr_data   (rf.WrData),
            .rd_data   (w_rd_data[g*DATA_W +: DATA_W]),
            .rd_ready  (w_rd_ready[g])
         );
      end
   endgenerate

   assign rf.RdData     = w_rd_data;
   assign rf.RdReady    = w_rd_ready;
   assign rf.RsvStall   = w_rsv_stall;
   assign rf.PendingCnt = r_pending;

endmodule : regfile_scoreboard
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_scoreboard
//  Purpose  : Self-checking bench for regfile_scoreboard: reference model
//             pushes expected outputs, compared when the DUT settles.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_scoreboard;
   import regfile_scoreboard_pkg::*;

   localparam int DW  = 64;
   localparam int NR  = 32;
   localparam int NRD = 2;
   localparam int AW  = 5;
   localparam int ZR  = NR - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   regfile_scoreboard_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD)) rf ();

   regfile_scoreboard #(
      .DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .ZERO_REG(ZR)
   ) dut (
      .Clk    (clk),
      .ResetN (rst_n),
      .rf     (rf)
   );

   typedef struct {
      string       tag;
      int          kind;   // 0 data, 1 ready, 2 stall, 3 pending
      int          port;
      logic [63:0] exp;
   } exp_t;

   exp_t        sb [$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [63:0] m_regs [NR];
   logic        m_busy [NR];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] observe(input int kind, input int port);
      case (kind)
         0:       return rf.RdData[port*DW +: DW];
         1:       return 64'(rf.RdReady[port]);
         2:       return 64'(rf.RsvStall);
         default: return 64'(rf.PendingCnt);
      endcase
   endfunction

   function automatic int model_pending();
      int n = 0;
      for (int i = 0; i < NR; i++) n += int'(m_busy[i]);
      return n;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NR; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
   endtask

   // Drive one cycle of stimulus just after a rising edge, check at the
   // falling edge, then advance the model at the next rising edge.
   task automatic cycle(input logic re, input int ra, input logic we, input int wa,
                        input logic [63:0] wd, input int a0, input int a1);
      logic  stall;
      int    addrs [2];
      exp_t  e;
      rf.RsvEn   = re;
      rf.RsvAddr = AW'(ra);
      rf.WrEn    = we;
      rf.WrAddr  = AW'(wa);
      rf.WrData  = wd;
      rf.RdAddr  = {AW'(a1), AW'(a0)};
      addrs[0] = a0;
      addrs[1] = a1;
      stall = rst_n && re && (ra != ZR) && m_busy[ra] && !(we && (wa == ra));
      for (int p = 0; p < NRD; p++) begin
         logic [63:0] d;
         logic        r;
         if (!rst_n || addrs[p] == ZR) begin
            d = '0; r = 1'b1;
         end else if (we && wa == addrs[p]) begin
            d = wd; r = 1'b1;
         end else begin
            d = m_regs[addrs[p]]; r = !m_busy[addrs[p]];
         end
         sb.push_back('{$sformatf("rd%0d_data_a%0d", p, addrs[p]), 0, p, d});
         sb.push_back('{$sformatf("rd%0d_ready_a%0d", p, addrs[p]), 1, p, 64'(r)});
      end
      sb.push_back('{"rsv_stall", 2, 0, 64'(stall)});
      sb.push_back('{"pending_cnt", 3, 0, rst_n ? 64'(model_pending()) : 64'd0});
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check(e.tag, observe(e.kind, e.port), e.exp);
      end
      @(posedge clk);
      if (rst_n) begin
         if (we && wa != ZR) m_regs[wa] = wd;
         if (we) m_busy[wa] = 1'b0;
         if (re && !stall && ra != ZR) m_busy[ra] = 1'b1;
      end else begin
         model_reset();
      end
      #1;
   endtask

   function automatic int rnd_addr();
      if ($urandom_range(0, 9) == 0) return ZR;
      return int'($urandom_range(0, 6));
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      rf.RsvEn = 1'b0; rf.RsvAddr = '0; rf.WrEn = 1'b0;
      rf.WrAddr = '0; rf.WrData = '0; rf.RdAddr = '0;
      model_reset();
      @(posedge clk); #1;

      // Held in reset with active bypass/reservation inputs.
      cycle(1'b1, 5, 1'b1, 7, 64'h1234, 7, 5);
      rst_n = 1'b1;

      // Same-cycle bypass, then stored value.
      cycle(1'b0, 0, 1'b1, 7, 64'h1234, 7, 0);
      cycle(1'b0, 0, 1'b0, 0, 64'h0, 7, 7);
      check("bypass_stored", rf.RdData[DW-1:0], 64'h1234);

      // Zero register write and reservation are inert.
      cycle(1'b1, ZR, 1'b1, ZR, 64'hFFFF, ZR, ZR);
      cycle(1'b0, 0, 1'b0, 0, 64'h0, ZR, 7);
      check("zero_pending", 64'(rf.PendingCnt), 64'd0);

      // WAW on r4.
      cycle(1'b1, 4, 1'b0, 0, 64'h0, 4, 0);
      cycle(1'b1, 4, 1'b0, 0, 64'h0, 4, 0);
      check("waw_pending", 64'(rf.PendingCnt), 64'd1);
      cycle(1'b1, 4, 1'b1, 4, 64'h55, 4, 0);
      cycle(1'b0, 0, 1'b0, 0, 64'h0, 4, 0);
      check("waw_r4_data", rf.RdData[DW-1:0], 64'h55);
      cycle(1'b0, 0, 1'b1, 4, 64'h66, 4, 0);

      // Asynchronous reset in mid-operation.
      cycle(1'b1, 5, 1'b1, 3, 64'hAA, 3, 5);
      rf.WrEn = 1'b1; rf.WrAddr = AW'(3); rf.WrData = 64'hBB;
      rf.RsvEn = 1'b1; rf.RsvAddr = AW'(6); rf.RdAddr = {AW'(5), AW'(3)};
      rst_n = 1'b0;
      #2;
      check("rst_rd0_data", rf.RdData[DW-1:0], 64'h0);
      check("rst_ready", 64'(rf.RdReady), 64'h3);
      check("rst_stall", 64'(rf.RsvStall), 64'h0);
      check("rst_pending", 64'(rf.PendingCnt), 64'h0);
      model_reset();
      rf.WrEn = 1'b0; rf.RsvEn = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      cycle(1'b0, 0, 1'b0, 0, 64'h0, 3, 5);

      // Fill every non-zero register, read all back, then drain.
      for (int i = 0; i < ZR; i++) cycle(1'b1, i, 1'b0, 0, 64'h0, i, (i + 1) % NR);
      check("fill_pending", 64'(rf.PendingCnt), 64'(NR - 1));
      for (int i = 0; i < NR; i += 2) cycle(1'b0, 0, 1'b0, 0, 64'h0, i, i + 1);
      for (int i = 0; i < ZR; i++) cycle(1'b0, 0, 1'b1, i, 64'(i) * 64'h0101, i, ZR - i);
      check("drain_pending", 64'(rf.PendingCnt), 64'd0);

      // Random hazard mix over a small address window.
      for (int n = 0; n < 300; n++) begin
         cycle(1'($urandom_range(0, 1)), rnd_addr(), 1'($urandom_range(0, 2) == 0),
               rnd_addr(), {$urandom, $urandom}, rnd_addr(), rnd_addr());
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_regfile_scoreboard
`default_nettype wire

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL provide parameter DATA_W, default 64, register width in bits.
REQ-002 SHALL provide parameter NUM_REGS, default 32, architectural register count (power of two, >=4).
REQ-003 SHALL provide parameter NUM_RD, default 2, number of independent read ports (1..4).
REQ-004 SHALL provide parameter ZERO_REG, default NUM_REGS-1, index of the hard-wired zero register; derived ADDR_W = clog2(NUM_REGS).
REQ-005 SHALL have port Clk  input  1  single clock, all state updates on rising edge.
REQ-006 SHALL have port ResetN  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port RdAddr  input  NUM_RD*ADDR_W  packed read addresses, port i at bits [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port RdData  output  NUM_RD*DATA_W  packed read data, same packing.
REQ-009 SHALL have port RdReady  output  NUM_RD  per-port flag: data is architecturally current (no pending writer).
REQ-010 SHALL have port WrEn / WrAddr / WrData  input  1 / ADDR_W / DATA_W  writeback request.
REQ-011 SHALL have port RsvEn / RsvAddr  input  1 / ADDR_W  reserve destination (mark pending writer).
REQ-012 SHALL have port RsvStall  output  1  reservation refused this cycle (WAW hazard).
REQ-013 SHALL have port PendingCnt  output  ADDR_W+1  number of currently reserved registers.

Function
REQ-014 SHALL update register storage on the rising Clk edge when WrEn=1 and WrAddr!=ZERO_REG; WrAddr=ZERO_REG writes are discarded.
REQ-015 SHALL drive each RdData port combinationally: ZERO_REG reads return 0; else if WrEn=1 and WrAddr==RdAddr the value is WrData (same-cycle bypass); else the stored value.
REQ-016 SHALL hold one busy bit per register; ZERO_REG busy bit constant 0.
REQ-017 SHALL refuse a reservation (RsvStall=1, combinational) when RsvEn=1, RsvAddr!=ZERO_REG, busy[RsvAddr]=1, and NOT (WrEn=1 and WrAddr==RsvAddr); RsvStall=0 otherwise.
REQ-018 SHALL, on an accepted reservation to a non-zero register, set busy[RsvAddr] at the next edge; RsvEn to ZERO_REG is accepted with no state change.
REQ-019 SHALL clear busy[WrAddr] at the next edge on any WrEn=1, regardless of prior busy state.
REQ-020 SHALL, on simultaneous accepted reservation and write to the same address, leave the busy bit set (new writer wins) while still committing WrData.
REQ-021 SHALL drive RdReady[i] = 1 when RdAddr[i]==ZERO_REG, busy[RdAddr[i]]=0, or the read is bypassed per REQ-015; else 0.
REQ-022 SHALL register PendingCnt as the population count of busy bits after each edge; single-cycle net change in {-1,0,+1}; never exceeds NUM_REGS-1.
REQ-023 SHALL have zero-cycle read latency and one-cycle write/reservation latency to stored state.

Reset
REQ-024 SHALL, while ResetN=0, asynchronously clear all registers to 0, all busy bits to 0, PendingCnt to 0.
REQ-025 SHALL, during reset, yield RdData=0 and RdReady all-1 regardless of bypass inputs; RsvStall=0.
REQ-026 SHALL discard any write or reservation coincident with reset assertion; first state update occurs on the first rising edge after ResetN rises.

Structure
REQ-027 SHALL place default parameter values and the ZERO_REG convention in the shared processor package for reuse by decode and hazard logic.
REQ-028 SHALL implement the read-port mux plus bypass as one sub-module, regfile_read_port, instantiated NUM_RD times via generate.

Verification
REQ-029 Reset mid-operation: reserve r5, write r3=0xAA, pulse ResetN low -> r3 reads 0, PendingCnt=0, RdReady all 1.
REQ-030 Bypass: WrEn=1, WrAddr=7, WrData=0x1234, RdAddr port0=7 same cycle -> RdData0=0x1234, RdReady0=1; next cycle stored value 0x1234.
REQ-031 Zero register: write 0xFFFF to ZERO_REG, reserve ZERO_REG -> reads 0, RdReady=1, PendingCnt unchanged, RsvStall=0.
REQ-032 WAW: reserve r4 (cycle 0), reserve r4 again (cycle 1) -> RsvStall=1, PendingCnt=1; cycle 2 reserve r4 with WrEn r4=0x55 -> RsvStall=0, busy stays set, r4=0x55, PendingCnt=1.
REQ-033 Fill: reserve all NUM_REGS-1 non-zero registers in consecutive cycles -> PendingCnt reaches 31 (default), all non-zero RdReady=0; writeback each -> PendingCnt returns to 0.
